// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU SELECT codes and the
// reserved-opcode test used when a request is granted.
package alu_share_ctrl_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    // Codes 100-111 have no ALU function and are answered with ERR instead.
    function automatic logic op_reserved(input logic [2:0] op);
        return (op >= 3'b100);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational; the last-served
// pointer moves only when the update strobe is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // last_port = 1 means port 1 was served last, so port 0 wins a tie.
    logic last_port;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_port ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_port <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_port <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// operands held for LATENCY cycles, result captured and returned with DONE.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             zero_out,
    output logic             err,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [2:0]       alu_select,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             port;
    logic             rsv;

    logic [1:0]       grant;
    logic             grant_en;
    logic [2:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    assign grant_en = (state == IDLE) && (req0 || req1);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .update (grant_en),
        .grant  (grant)
    );

    assign win_op = grant[1] ? op1 : op0;
    assign win_a  = grant[1] ? a1  : a0;
    assign win_b  = grant[1] ? b1  : b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            port       <= 1'b0;
            rsv        <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            res        <= '0;
            zero_out   <= 1'b0;
            err        <= 1'b0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_select <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        port  <= grant[1];
                        gnt0  <= grant[0];
                        gnt1  <= grant[1];
                        state <= EXEC;
                        // A reserved op leaves the ALU untouched and answers after a single wait cycle.
                        if (op_reserved(win_op)) begin
                            rsv <= 1'b1;
                            cnt <= CNT_W'(1);
                        end else begin
                            rsv        <= 1'b0;
                            cnt        <= CNT_W'(LATENCY);
                            alu_select <= win_op;
                            alu_data1  <= win_a;
                            alu_data2  <= win_b;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == CNT_W'(1)) begin
                        if (rsv) begin
                            res      <= '0;
                            zero_out <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            res      <= alu_result;
                            zero_out <= alu_zero;
                            err      <= 1'b0;
                        end
                        done0 <= ~port;
                        done1 <= port;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
